tof_mod_meas: RTL and testbench
===============================

Name: tof_mod_meas

Overview:
- Measurement receiver for ToF modulation clocks: the reader for the delay/duty/period clock generators.
- Observes one externally looped-back modulation signal (MODIN) inside a VALID window.
- Measures, in CLKIN cycles: DELAY from VALID rise to first MODIN rise, DUTY of the first pulse, PERIOD between the first two rising edges, and the total pulse count.
- Used for on-chip self-check of the illumination/demodulation timing; results are read over the host register path.

Parameters:
- SYNC_STAGES, 2, synchroniser depth applied identically to VALID and MODIN (minimum 2).
- CNT_W, 32, width of all measurement counters and result outputs.

Ports:
- CLKIN  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- VALID  in  1  measurement window, asynchronous to CLKIN.
- MODIN  in  1  modulation signal under test, asynchronous to CLKIN.
- DELAY_MEAS  out  CNT_W  cycles from synced VALID rise to first synced MODIN rise.
- DUTY_MEAS  out  CNT_W  high time of the first MODIN pulse.
- PERIOD_MEAS  out  CNT_W  cycles between the first and second MODIN rising edges.
- PULSE_CNT  out  CNT_W  number of MODIN rising edges inside the window.
- STATUS  out  3  [0] no edge seen, [1] no second edge, [2] first pulse truncated by VALID fall.
- DONE  out  1  one-cycle pulse when all results update.

Behaviour:
- Reset: all outputs 0, state IDLE, synchroniser flops 0.
- Synchronisation:
  - VALID and MODIN each pass through SYNC_STAGES flops, giving v_s and m_s; one further register gives v_d and m_d.
  - Edges are detected on the synced signals: vr = v_s & ~v_d; vf = ~v_s & v_d; mr = m_s & ~m_d.
  - Both signals see equal latency, so their relative timing is preserved.
- Cycle numbering: the cycle with vr=1 is cycle 0.
  - DELAY = index of the first cycle with mr=1, so mr in cycle 0 gives DELAY=0.
  - DUTY = number of consecutive cycles m_s=1 starting at that first rising-edge cycle.
  - PERIOD = cycle index of the second mr minus that of the first.
- MODIN already high at vr is not an edge; the block waits for a true rise.
- States:
  - IDLE: on vr, clear counters and go to WAIT_EDGE. In that same cycle, mr is evaluated with DELAY=0.
  - WAIT_EDGE: delay counter increments each cycle without mr. On mr: latch DELAY, set PULSE_CNT=1, start the duty and period counters at 1, go to FIRST_HIGH.
  - FIRST_HIGH: duty counter increments while m_s=1. On m_s=0: latch DUTY, go to MEASURE. The period counter keeps running.
  - MEASURE: on each mr, increment the pulse counter. On the first mr in this state, latch PERIOD. Stay in MEASURE.
  - Any non-IDLE state on vf: transfer results to the outputs, pulse DONE the following cycle, go to IDLE.
- vf priority: vf wins over a simultaneous mr or m_s fall; that last edge is not counted.
- Status flags, set on vf:
  - In WAIT_EDGE: all results 0, STATUS=3'b001.
  - In FIRST_HIGH: DUTY = partial count, PERIOD=0, STATUS=3'b110.
  - In MEASURE with no second edge: PERIOD=0, STATUS=3'b010.
  - Otherwise STATUS=0.
- Latency: DONE asserts SYNC_STAGES+2 CLKIN edges after raw VALID is first sampled low.
- Output holding: outputs are held until the next DONE. A new vr in the cycle after vf is honoured normally.
- Saturation: all counters saturate at all-ones and never wrap.
- VALID never high (or reset asserted mid-window): no DONE. Reset mid-window aborts with outputs cleared.

Optional Feature:
- Macro: TOF_MEAS_JITTER_EN.
- When defined:
  - Adds outputs PERIOD_MIN and PERIOD_MAX (CNT_W each), covering every rise-to-rise interval in the window.
  - Both update with DONE.
  - If fewer than 2 edges were seen, both read 0.
  - Reset value 0.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Generator-style stimulus: VALID rise, MODIN rises 5 cycles later, high 3, period 8, 4 pulses, VALID falls after the 4th pulse -> DELAY=5, DUTY=3, PERIOD=8, PULSE_CNT=4, STATUS=0, single DONE pulse 4 cycles after VALID low (SYNC_STAGES=2).
- MODIN rise in the same cycle as VALID rise -> DELAY=0; MODIN high before VALID with its first rise 10 cycles in -> DELAY=10.
- VALID window with MODIN static low -> all results 0, STATUS=3'b001, DONE pulses.
- VALID falls 2 cycles into the first pulse -> DUTY=2, PERIOD=0, PULSE_CNT=1, STATUS=3'b110.
- Back-to-back windows (VALID low 1 cycle) with DELAY 3 then 7 -> two DONE pulses, second reports DELAY=7; RST asserted mid-window -> outputs 0, no DONE.
- TOF_MEAS_JITTER_EN defined, periods 8,9,7 -> PERIOD=8, PERIOD_MIN=7, PERIOD_MAX=9.

Source files
------------

// File: rtl/tof_mod_meas.sv
// tof_mod_meas: measurement receiver for looped-back ToF modulation clocks.
// Measures DELAY, DUTY, PERIOD and pulse count of MODIN inside a VALID window.
//
// Ports:
//   CLKIN        system clock, rising edge
//   RST          asynchronous active-high reset
//   VALID        measurement window (asynchronous)
//   MODIN        modulation signal under test (asynchronous)
//   DELAY_MEAS   cycles from window start to first MODIN rise
//   DUTY_MEAS    high time of the first MODIN pulse
//   PERIOD_MEAS  cycles between first and second MODIN rise
//   PULSE_CNT    MODIN rising edges inside the window
//   STATUS       [0] no edge, [1] no second edge, [2] first pulse truncated
//   DONE         one-cycle pulse after the results update
//   PERIOD_MIN/PERIOD_MAX  only with TOF_MEAS_JITTER_EN defined:
//                min/max of every rise-to-rise interval in the window
module tof_mod_meas #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             CLKIN,
    input  logic             RST,
    input  logic             VALID,
    input  logic             MODIN,
    output logic [CNT_W-1:0] DELAY_MEAS,
    output logic [CNT_W-1:0] DUTY_MEAS,
    output logic [CNT_W-1:0] PERIOD_MEAS,
    output logic [CNT_W-1:0] PULSE_CNT,
`ifdef TOF_MEAS_JITTER_EN
    output logic [CNT_W-1:0] PERIOD_MIN,
    output logic [CNT_W-1:0] PERIOD_MAX,
`endif
    output logic [2:0]       STATUS,
    output logic             DONE
);

    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WAIT_EDGE  = 2'd1;
    localparam logic [1:0] FIRST_HIGH = 2'd2;
    localparam logic [1:0] MEASURE    = 2'd3;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (&x) ? x : x + ONE;
    endfunction

    logic [NS-1:0]    v_sync, m_sync;
    logic             v_s, m_s, v_d, m_d;
    logic             vr, vf, mr;

    logic [1:0]       state;
    logic [CNT_W-1:0] dly_cnt, duty_cnt, per_cnt, pulse_cnt;
    logic             have_per;
    logic             fin, done_pend;

    logic [CNT_W-1:0] fin_dly, fin_duty, fin_per, fin_pulse;
    logic [2:0]       fin_stat;

    // Both inputs share the same chain depth so their relative timing holds.
    always_ff @(posedge CLKIN or posedge RST) begin
        if (RST) begin
            v_sync <= '0;
            m_sync <= '0;
            v_d    <= 1'b0;
            m_d    <= 1'b0;
        end else begin
            v_sync <= {v_sync[NS-2:0], VALID};
            m_sync <= {m_sync[NS-2:0], MODIN};
            v_d    <= v_s;
            m_d    <= m_s;
        end
    end

    assign v_s = v_sync[NS-1];
    assign m_s = m_sync[NS-1];
    assign vr  = v_s & ~v_d;
    assign vf  = ~v_s & v_d;
    assign mr  = m_s & ~m_d;

    assign fin = vf && (state != IDLE);

    // Counters stop once their quantity is known, so they double as the
    // latched results until the window closes.
    always_ff @(posedge CLKIN or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            dly_cnt   <= '0;
            duty_cnt  <= '0;
            per_cnt   <= '0;
            pulse_cnt <= '0;
            have_per  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (vr) begin
                        dly_cnt   <= '0;
                        duty_cnt  <= '0;
                        per_cnt   <= '0;
                        pulse_cnt <= '0;
                        have_per  <= 1'b0;
                        if (mr) begin
                            duty_cnt  <= ONE;
                            per_cnt   <= ONE;
                            pulse_cnt <= ONE;
                            state     <= FIRST_HIGH;
                        end else begin
                            dly_cnt <= ONE;
                            state   <= WAIT_EDGE;
                        end
                    end
                end
                WAIT_EDGE: begin
                    if (vf) begin
                        state <= IDLE;
                    end else if (mr) begin
                        duty_cnt  <= ONE;
                        per_cnt   <= ONE;
                        pulse_cnt <= ONE;
                        state     <= FIRST_HIGH;
                    end else begin
                        dly_cnt <= sat_inc(dly_cnt);
                    end
                end
                FIRST_HIGH: begin
                    if (vf) begin
                        state <= IDLE;
                    end else begin
                        per_cnt <= sat_inc(per_cnt);
                        if (m_s) begin
                            duty_cnt <= sat_inc(duty_cnt);
                        end else begin
                            state <= MEASURE;
                        end
                    end
                end
                MEASURE: begin
                    if (vf) begin
                        state <= IDLE;
                    end else begin
                        if (mr) begin
                            pulse_cnt <= sat_inc(pulse_cnt);
                            have_per  <= 1'b1;
                        end
                        if (!have_per && !mr) begin
                            per_cnt <= sat_inc(per_cnt);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        fin_dly   = dly_cnt;
        fin_duty  = duty_cnt;
        fin_per   = '0;
        fin_pulse = pulse_cnt;
        fin_stat  = 3'b000;
        case (state)
            WAIT_EDGE: begin
                fin_dly   = '0;
                fin_duty  = '0;
                fin_pulse = '0;
                fin_stat  = 3'b001;
            end
            FIRST_HIGH: begin
                fin_stat = 3'b110;
            end
            MEASURE: begin
                fin_per  = have_per ? per_cnt : '0;
                fin_stat = have_per ? 3'b000 : 3'b010;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLKIN or posedge RST) begin
        if (RST) begin
            DELAY_MEAS  <= '0;
            DUTY_MEAS   <= '0;
            PERIOD_MEAS <= '0;
            PULSE_CNT   <= '0;
            STATUS      <= 3'b000;
            done_pend   <= 1'b0;
            DONE        <= 1'b0;
        end else begin
            done_pend <= fin;
            DONE      <= done_pend;
            if (fin) begin
                DELAY_MEAS  <= fin_dly;
                DUTY_MEAS   <= fin_duty;
                PERIOD_MEAS <= fin_per;
                PULSE_CNT   <= fin_pulse;
                STATUS      <= fin_stat;
            end
        end
    end

`ifdef TOF_MEAS_JITTER_EN
    logic [CNT_W-1:0] iv_cnt, pmin, pmax;

    // iv_cnt counts cycles since the most recent MODIN rise.
    always_ff @(posedge CLKIN or posedge RST) begin
        if (RST) begin
            iv_cnt     <= '0;
            pmin       <= '0;
            pmax       <= '0;
            PERIOD_MIN <= '0;
            PERIOD_MAX <= '0;
        end else begin
            if (fin) begin
                PERIOD_MIN <= (state == MEASURE && have_per) ? pmin : '0;
                PERIOD_MAX <= (state == MEASURE && have_per) ? pmax : '0;
            end
            case (state)
                IDLE:       iv_cnt <= ONE;
                WAIT_EDGE:  iv_cnt <= ONE;
                FIRST_HIGH: begin
                    if (!vf) iv_cnt <= sat_inc(iv_cnt);
                end
                MEASURE: begin
                    if (!vf) begin
                        if (mr) begin
                            iv_cnt <= ONE;
                            if (!have_per || iv_cnt < pmin) pmin <= iv_cnt;
                            if (!have_per || iv_cnt > pmax) pmax <= iv_cnt;
                        end else begin
                            iv_cnt <= sat_inc(iv_cnt);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_tof_mod_meas.sv
// tb_tof_mod_meas: randomized and directed bench for tof_mod_meas.
// Expected results come from a window-level model over the driven samples.
module tb_tof_mod_meas;

    localparam int SYNC = 2;
    localparam int W    = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid;
    logic         modin;
    logic [W-1:0] dly, duty, per, pcnt;
`ifdef TOF_MEAS_JITTER_EN
    logic [W-1:0] pmin, pmax;
`endif
    logic [2:0]   stat;
    logic         done;

    tof_mod_meas #(
        .SYNC_STAGES(SYNC),
        .CNT_W      (W)
    ) dut (
        .CLKIN      (clk),
        .RST        (rst),
        .VALID      (valid),
        .MODIN      (modin),
        .DELAY_MEAS (dly),
        .DUTY_MEAS  (duty),
        .PERIOD_MEAS(per),
        .PULSE_CNT  (pcnt),
`ifdef TOF_MEAS_JITTER_EN
        .PERIOD_MIN (pmin),
        .PERIOD_MAX (pmax),
`endif
        .STATUS     (stat),
        .DONE       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned  edge_n;
        logic [W-1:0] d;
        logic [W-1:0] du;
        logic [W-1:0] p;
        logic [W-1:0] pc;
        logic [W-1:0] mn;
        logic [W-1:0] mx;
        logic [2:0]   st;
    } res_t;

    res_t        expq[$];
    res_t        actq[$];
    bit          wq[$];
    int unsigned ecount = 0;
    int          n_cmp  = 0;
    int          n_bad  = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic m);
        valid = v;
        modin = m;
        @(posedge clk);
        ecount++;
        @(negedge clk);
    endtask

    task automatic flush(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'($urandom));
    endtask

    task automatic add(input bit b, input int n);
        for (int k = 0; k < n; k++) wq.push_back(b);
    endtask

    // Window model: index 0 is the first sample with VALID high.
    function automatic res_t model(input bit mp, input int len);
        res_t r;
        int   rises[$];
        bit   prev;
        int   i, h, iv;
        r = '{default: 0};
        prev = mp;
        for (int k = 0; k < len; k++) begin
            if (wq[k] && !prev) rises.push_back(k);
            prev = wq[k];
        end
        if (rises.size() == 0) begin
            r.st = 3'b001;
            return r;
        end
        r.d = rises[0];
        i = rises[0];
        h = 0;
        while (i < len && wq[i]) begin
            h++;
            i++;
        end
        r.du = h;
        if (i == len) begin
            r.pc = 1;
            r.st = 3'b110;
            return r;
        end
        r.pc = rises.size();
        if (rises.size() < 2) begin
            r.st = 3'b010;
            return r;
        end
        r.p  = rises[1] - rises[0];
        r.mn = r.p;
        r.mx = r.p;
        for (int k = 1; k < rises.size(); k++) begin
            iv = rises[k] - rises[k-1];
            if (iv < r.mn) r.mn = iv;
            if (iv > r.mx) r.mx = iv;
        end
        return r;
    endfunction

    task automatic window(input bit mp, input int gap);
        res_t e;
        for (int g = 0; g < gap; g++)
            step(1'b0, (g == gap - 1) ? mp : 1'($urandom));
        e = model(mp, wq.size());
        e.edge_n = ecount + wq.size() + SYNC + 2;
        expq.push_back(e);
        for (int i = 0; i < wq.size(); i++) step(1'b1, wq[i]);
    endtask

    always @(negedge clk) begin : mon
        res_t r;
        if (done === 1'b1 && rst === 1'b0) begin
            r = '{default: 0};
            r.edge_n = ecount;
            r.d  = dly;
            r.du = duty;
            r.p  = per;
            r.pc = pcnt;
            r.st = stat;
`ifdef TOF_MEAS_JITTER_EN
            r.mn = pmin;
            r.mx = pmax;
`endif
            actq.push_back(r);
        end
    end

    initial begin
        int          n;
        int unsigned e0;
        bit          cur;
        int          len;

        rst   = 1'b1;
        valid = 1'b0;
        modin = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("rst_delay", dly, 0);
        chk("rst_status", stat, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        flush(3);

        // generator-style: delay 5, high 3, period 8, 4 pulses
        wq.delete();
        add(0, 5);
        repeat (4) begin
            add(1, 3);
            add(0, 5);
        end
        window(1'b0, 3);
        e0 = ecount + 1;
        flush(8);
        chk("gen_delay", dly, 5);
        chk("gen_duty", duty, 3);
        chk("gen_period", per, 8);
        chk("gen_pulses", pcnt, 4);
        chk("gen_status", stat, 0);
        chk("gen_latency", actq[actq.size()-1].edge_n - e0 + 1, SYNC + 2);

        // rise coincident with window start
        wq.delete();
        add(1, 1); add(0, 3); add(1, 2); add(0, 2);
        window(1'b0, 2);
        flush(6);
        chk("d0_delay", dly, 0);

        // MODIN already high at window start, first true rise at 10
        wq.delete();
        add(1, 5); add(0, 5); add(1, 3); add(0, 4);
        window(1'b1, 2);
        flush(6);
        chk("d10_delay", dly, 10);

        // static low
        wq.delete();
        add(0, 12);
        window(1'b0, 2);
        flush(6);
        chk("nolo_status", stat, 3'b001);
        chk("nolo_pulses", pcnt, 0);

        // window closes two cycles into the first pulse
        wq.delete();
        add(0, 4); add(1, 2);
        window(1'b0, 2);
        flush(6);
        chk("trunc_duty", duty, 2);
        chk("trunc_period", per, 0);
        chk("trunc_pulses", pcnt, 1);
        chk("trunc_status", stat, 3'b110);

        // back-to-back windows, VALID low for one cycle between them
        wq.delete();
        add(0, 3); add(1, 2); add(0, 2);
        window(1'b0, 3);
        wq.delete();
        add(0, 7); add(1, 2); add(0, 3);
        window(1'b0, 1);
        flush(6);
        chk("b2b_delay", dly, 7);

        // periods 8, 9, 7
        wq.delete();
        add(0, 2); add(1, 3); add(0, 5); add(1, 3); add(0, 6);
        add(1, 3); add(0, 4); add(1, 2); add(0, 3);
        window(1'b0, 2);
        flush(6);
        chk("jit_period", per, 8);
`ifdef TOF_MEAS_JITTER_EN
        chk("jit_min", pmin, 7);
        chk("jit_max", pmax, 9);
`endif

        // reset in the middle of a window: outputs cleared, no DONE
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        rst = 1'b1;
        step(1'b1, 1'b1);
        chk("mid_rst_period", per, 0);
        chk("mid_rst_pulses", pcnt, 0);
        chk("mid_rst_done", done, 0);
        step(1'b0, 1'b0);
        rst = 1'b0;
        flush(10);

        // random windows
        repeat (60) begin
            wq.delete();
            len = $urandom_range(1, 40);
            cur = 1'($urandom);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 2) == 0) cur = ~cur;
                wq.push_back(cur);
            end
            window(1'($urandom), $urandom_range(1, 5));
        end
        flush(12);

        chk("done_count", actq.size(), expq.size());
        n = (actq.size() < expq.size()) ? actq.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("w%0d_edge", i), actq[i].edge_n, expq[i].edge_n);
            chk($sformatf("w%0d_delay", i), actq[i].d, expq[i].d);
            chk($sformatf("w%0d_duty", i), actq[i].du, expq[i].du);
            chk($sformatf("w%0d_period", i), actq[i].p, expq[i].p);
            chk($sformatf("w%0d_pulses", i), actq[i].pc, expq[i].pc);
            chk($sformatf("w%0d_status", i), actq[i].st, expq[i].st);
`ifdef TOF_MEAS_JITTER_EN
            chk($sformatf("w%0d_pmin", i), actq[i].mn, expq[i].mn);
            chk($sformatf("w%0d_pmax", i), actq[i].mx, expq[i].mx);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
